// File: rtl/matrix_seq_ctrl.sv
// Command-driven matrix address sequencer: one command in, one address beat per cycle out (valid/ready).
// Optional build macro MATRIX_SEQ_BOUND_CHK_EN adds an err output and rejects commands that would wrap.
module matrix_seq_ctrl #(
    parameter int ADDR_MSB         = 11,
    parameter int MAT_IDX_SIZE_MSB = 3
) (
    input  logic                      CLK,
    input  logic                      RST_L,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic                      cmd_transpose,
    input  logic [ADDR_MSB:0]         cmd_base,
    input  logic [MAT_IDX_SIZE_MSB:0] row_idx_size,
    input  logic [MAT_IDX_SIZE_MSB:0] col_idx_size,
    output logic                      a_valid,
    input  logic                      a_ready,
    output logic [ADDR_MSB:0]         a,
    output logic                      we,
    output logic                      a_last,
    output logic                      done,
    output logic                      busy,
`ifdef MATRIX_SEQ_BOUND_CHK_EN
    output logic                      err,
`endif
    output logic [1:0]                dbg_state
);

    localparam int ADDR_W = ADDR_MSB + 1;
    localparam int IDX_W  = MAT_IDX_SIZE_MSB + 1;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // a producer keeps its payload stable while valid is high and ready is low.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] base_q, ncols_q;
    logic [IDX_W-1:0]  rmax_q, cmax_q;
    logic              tr_q;
    logic [IDX_W-1:0]  r, c, r_nx, c_nx;

    logic              cmd_ready_nx, a_valid_nx, we_nx, a_last_nx, done_nx, busy_nx;
    logic [ADDR_W-1:0] a_nx;
    logic              accept, fire, overflow;

    assign accept    = cmd_valid & cmd_ready;
    assign fire      = a_valid & a_ready;
    assign dbg_state = state;

`ifdef MATRIX_SEQ_BOUND_CHK_EN
    localparam int BC_W  = 2 * IDX_W + 2;
    localparam int SUM_W = ADDR_W + BC_W + 1;
    logic [BC_W-1:0]  beat_count;
    logic [SUM_W-1:0] end_addr;
    logic             err_nx;

    assign beat_count = (BC_W'(row_idx_size) + BC_W'(1)) * (BC_W'(col_idx_size) + BC_W'(1));
    assign end_addr   = SUM_W'(cmd_base) + SUM_W'(beat_count) - SUM_W'(1);
    assign overflow   = end_addr > SUM_W'({ADDR_W{1'b1}});
`else
    assign overflow = 1'b0;
`endif

    always_comb begin
        state_nx     = state;
        cmd_ready_nx = cmd_ready;
        a_valid_nx   = a_valid;
        a_nx         = a;
        we_nx        = we;
        a_last_nx    = a_last;
        done_nx      = 1'b0;
        busy_nx      = busy;
        r_nx         = r;
        c_nx         = c;
`ifdef MATRIX_SEQ_BOUND_CHK_EN
        err_nx       = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (accept) begin
                    cmd_ready_nx = 1'b0;
                    busy_nx      = 1'b1;
                    r_nx         = '0;
                    c_nx         = '0;
                    if (overflow) begin
                        state_nx = S_DONE;
                        done_nx  = 1'b1;
`ifdef MATRIX_SEQ_BOUND_CHK_EN
                        err_nx   = 1'b1;
`endif
                    end else begin
                        state_nx   = S_RUN;
                        a_valid_nx = 1'b1;
                        a_nx       = cmd_base;
                        we_nx      = cmd_write;
                        a_last_nx  = (row_idx_size == '0) && (col_idx_size == '0);
                    end
                end
            end
            S_RUN: begin
                if (fire) begin
                    if (a_last) begin
                        state_nx   = S_DONE;
                        a_valid_nx = 1'b0;
                        we_nx      = 1'b0;
                        a_last_nx  = 1'b0;
                        done_nx    = 1'b1;
                    end else begin
                        // Row-major steps are always +1 because each row ends one below the next row start.
                        if (!tr_q) begin
                            a_nx = a + ADDR_W'(1);
                            if (c == cmax_q) begin
                                c_nx = '0;
                                r_nx = r + IDX_W'(1);
                            end else begin
                                c_nx = c + IDX_W'(1);
                            end
                        end else if (r == rmax_q) begin
                            r_nx = '0;
                            c_nx = c + IDX_W'(1);
                            a_nx = base_q + ADDR_W'(c_nx);
                        end else begin
                            r_nx = r + IDX_W'(1);
                            a_nx = a + ncols_q;
                        end
                        a_last_nx = (r_nx == rmax_q) && (c_nx == cmax_q);
                    end
                end
            end
            S_DONE: begin
                state_nx     = S_IDLE;
                busy_nx      = 1'b0;
                cmd_ready_nx = 1'b1;
            end
            default: begin
                state_nx     = S_IDLE;
                cmd_ready_nx = 1'b1;
                a_valid_nx   = 1'b0;
                we_nx        = 1'b0;
                a_last_nx    = 1'b0;
                busy_nx      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_L) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            a_valid   <= 1'b0;
            a         <= '0;
            we        <= 1'b0;
            a_last    <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            r         <= '0;
            c         <= '0;
`ifdef MATRIX_SEQ_BOUND_CHK_EN
            err       <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            cmd_ready <= cmd_ready_nx;
            a_valid   <= a_valid_nx;
            a         <= a_nx;
            we        <= we_nx;
            a_last    <= a_last_nx;
            done      <= done_nx;
            busy      <= busy_nx;
            r         <= r_nx;
            c         <= c_nx;
`ifdef MATRIX_SEQ_BOUND_CHK_EN
            err       <= err_nx;
`endif
        end
    end

    // Command fields are captured once and held for the whole pass.
    always_ff @(posedge CLK) begin
        if (!RST_L) begin
            base_q  <= '0;
            ncols_q <= '0;
            rmax_q  <= '0;
            cmax_q  <= '0;
            tr_q    <= 1'b0;
        end else if (accept) begin
            base_q  <= cmd_base;
            ncols_q <= ADDR_W'(col_idx_size) + ADDR_W'(1);
            rmax_q  <= row_idx_size;
            cmax_q  <= col_idx_size;
            tr_q    <= cmd_transpose;
        end
    end

endmodule

// File: tb/tb_matrix_seq_ctrl.sv
// Bench for matrix_seq_ctrl: directed vector table, reset/stall corner cases and randomized commands
// checked against a loop-based address model.
module tb_matrix_seq_ctrl;

    localparam int ADDR_MSB = 11;
    localparam int IDX_MSB  = 3;

    logic              CLK = 1'b0;
    logic              RST_L;
    logic              cmd_valid, cmd_ready, cmd_write, cmd_transpose;
    logic [ADDR_MSB:0] cmd_base;
    logic [IDX_MSB:0]  row_idx_size, col_idx_size;
    logic              a_valid, a_ready, we, a_last, done, busy;
    logic [ADDR_MSB:0] a;
    logic [1:0]        dbg_state;
`ifdef MATRIX_SEQ_BOUND_CHK_EN
    logic              err;
`endif

    int errors = 0;
    int checks = 0;
    logic [ADDR_MSB:0] exp_q[$];

    always #5 CLK = ~CLK;

    matrix_seq_ctrl #(.ADDR_MSB(ADDR_MSB), .MAT_IDX_SIZE_MSB(IDX_MSB)) dut (
        .CLK(CLK), .RST_L(RST_L),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_transpose(cmd_transpose), .cmd_base(cmd_base),
        .row_idx_size(row_idx_size), .col_idx_size(col_idx_size),
        .a_valid(a_valid), .a_ready(a_ready), .a(a), .we(we), .a_last(a_last),
        .done(done), .busy(busy),
`ifdef MATRIX_SEQ_BOUND_CHK_EN
        .err(err),
`endif
        .dbg_state(dbg_state)
    );

    typedef struct {
        logic             w;
        logic             tr;
        logic [ADDR_MSB:0] base;
        logic [IDX_MSB:0] rs;
        logic [IDX_MSB:0] cs;
        int               stall_beat;
        int               stall_len;
        logic [ADDR_MSB:0] exp_first;
        logic [ADDR_MSB:0] exp_final;
        int               exp_beats;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected address stream straight from the traversal definition.
    function automatic void model(input logic tr, input logic [ADDR_MSB:0] base,
                                  input logic [IDX_MSB:0] rs, input logic [IDX_MSB:0] cs);
        int rows, cols;
        exp_q.delete();
        rows = int'(rs) + 1;
        cols = int'(cs) + 1;
`ifdef MATRIX_SEQ_BOUND_CHK_EN
        if (int'(base) + rows * cols - 1 > 4095) return;
`endif
        if (!tr) begin
            for (int r = 0; r < rows; r++)
                for (int c = 0; c < cols; c++)
                    exp_q.push_back(12'((int'(base) + r * cols + c) % 4096));
        end else begin
            for (int c = 0; c < cols; c++)
                for (int r = 0; r < rows; r++)
                    exp_q.push_back(12'((int'(base) + r * cols + c) % 4096));
        end
    endfunction

    task automatic run_cmd(input logic w, input logic tr, input logic [ADDR_MSB:0] base,
                           input logic [IDX_MSB:0] rs, input logic [IDX_MSB:0] cs,
                           input int stall_beat, input int stall_len, input bit rnd_ready,
                           output int n_beats, output logic [ADDR_MSB:0] first_a,
                           output logic [ADDR_MSB:0] last_a);
        bit got_last = 0;
        bit held = 0;
        logic [ADDR_MSB:0] held_a;
        logic held_last;
        logic [ADDR_MSB:0] e;
        int stall_cnt = 0;
        logic rdy;
        n_beats = 0;
        first_a = '0;
        last_a  = '0;
        model(tr, base, rs, cs);
        @(negedge CLK);
        check("cmd_ready_idle", cmd_ready, 1);
        check("busy_idle", busy, 0);
        cmd_valid = 1; cmd_write = w; cmd_transpose = tr; cmd_base = base;
        row_idx_size = rs; col_idx_size = cs; a_ready = 0;
        @(negedge CLK);
        cmd_valid = 0;
        cmd_write = 1'($urandom); cmd_transpose = 1'($urandom); cmd_base = 12'($urandom);
        row_idx_size = 4'($urandom); col_idx_size = 4'($urandom);
`ifdef MATRIX_SEQ_BOUND_CHK_EN
        if (exp_q.size() == 0) begin
            check("ovf_done", done, 1);
            check("ovf_err", err, 1);
            check("ovf_a_valid", a_valid, 0);
            @(negedge CLK);
            check("ovf_done_clr", done, 0);
            check("ovf_err_clr", err, 0);
            check("ovf_cmd_ready", cmd_ready, 1);
            return;
        end
`endif
        for (int cyc = 0; cyc < 2000 && !got_last; cyc++) begin
            if (cyc > 0) @(negedge CLK);
            if (held) begin
                check("hold_a", a, held_a);
                check("hold_last", a_last, held_last);
            end
            held = 0;
            cmd_valid = 1'($urandom);
            cmd_base = 12'($urandom);
            row_idx_size = 4'($urandom);
            cmd_write = 1'($urandom);
            if (n_beats == stall_beat && stall_cnt < stall_len) begin
                rdy = 0;
                stall_cnt++;
            end else if (rnd_ready) begin
                rdy = ($urandom_range(0, 3) != 0);
            end else begin
                rdy = 1;
            end
            a_ready = rdy;
            check("a_valid_run", a_valid, 1);
            if (a_valid) begin
                check("we_run", we, w);
                if (rdy) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 1, 0);
                        got_last = 1;
                    end else begin
                        e = exp_q.pop_front();
                        check("addr", a, e);
                        check("a_last", a_last, exp_q.size() == 0);
                        if (n_beats == 0) first_a = a;
                        last_a = a;
                        n_beats++;
                        if (a_last) got_last = 1;
                    end
                end else begin
                    held = 1; held_a = a; held_last = a_last;
                end
            end
        end
        if (!got_last) check("beat_timeout", 0, 1);
        @(negedge CLK);
        cmd_valid = 0; a_ready = 0;
        check("done_pulse", done, 1);
        check("busy_done", busy, 1);
        check("a_valid_done", a_valid, 0);
        check("we_done", we, 0);
        check("cmd_ready_done", cmd_ready, 0);
        check("beats_left", exp_q.size(), 0);
        @(negedge CLK);
        check("done_clr", done, 0);
        check("busy_clr", busy, 0);
        check("cmd_ready_back", cmd_ready, 1);
    endtask

    initial begin
        int nb;
        logic [ADDR_MSB:0] fa, la;
        vecs[0] = '{1'b0, 1'b0, 12'h100, 4'd1, 4'd2, -1, 0, 12'h100, 12'h105, 6};
        vecs[1] = '{1'b0, 1'b1, 12'h100, 4'd1, 4'd2, -1, 0, 12'h100, 12'h105, 6};
        vecs[2] = '{1'b1, 1'b0, 12'h3FF, 4'd0, 4'd0, -1, 0, 12'h3FF, 12'h3FF, 1};
        vecs[3] = '{1'b0, 1'b0, 12'h100, 4'd1, 4'd1, 1, 3, 12'h100, 12'h103, 4};
`ifdef MATRIX_SEQ_BOUND_CHK_EN
        vecs[4] = '{1'b0, 1'b0, 12'hFFE, 4'd1, 4'd1, -1, 0, 12'h000, 12'h000, 0};
`else
        vecs[4] = '{1'b0, 1'b0, 12'hFFE, 4'd1, 4'd1, -1, 0, 12'hFFE, 12'h001, 4};
`endif
        vecs[5] = '{1'b0, 1'b1, 12'h010, 4'd3, 4'd0, -1, 0, 12'h010, 12'h013, 4};
        vecs[6] = '{1'b1, 1'b1, 12'h200, 4'd2, 4'd3, 2, 2, 12'h200, 12'h20B, 12};
        vecs[7] = '{1'b0, 1'b0, 12'hF00, 4'd15, 4'd15, -1, 0, 12'hF00, 12'hFFF, 256};

        RST_L = 0; cmd_valid = 0; a_ready = 0; cmd_write = 0; cmd_transpose = 0;
        cmd_base = '0; row_idx_size = '0; col_idx_size = '0;
        repeat (3) @(negedge CLK);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_a_valid", a_valid, 0);
        check("rst_a", a, 0);
        check("rst_we", we, 0);
        check("rst_a_last", a_last, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        RST_L = 1;

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].w, vecs[i].tr, vecs[i].base, vecs[i].rs, vecs[i].cs,
                    vecs[i].stall_beat, vecs[i].stall_len, 0, nb, fa, la);
            check($sformatf("vec%0d_beats", i), nb, vecs[i].exp_beats);
            if (vecs[i].exp_beats > 0) begin
                check($sformatf("vec%0d_first", i), fa, vecs[i].exp_first);
                check($sformatf("vec%0d_final", i), la, vecs[i].exp_final);
            end
        end

        // Reset in the middle of a 4x4 pass, then a fresh command from its own base.
        @(negedge CLK);
        cmd_valid = 1; cmd_write = 0; cmd_transpose = 0; cmd_base = 12'h040;
        row_idx_size = 4'd3; col_idx_size = 4'd3; a_ready = 1;
        @(negedge CLK);
        cmd_valid = 0;
        repeat (4) @(negedge CLK);
        check("midrst_beat5", a, 12'h044);
        RST_L = 0;
        @(negedge CLK);
        check("midrst_a_valid", a_valid, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_a", a, 0);
        check("midrst_done", done, 0);
        RST_L = 1; a_ready = 0;
        run_cmd(1'b1, 1'b0, 12'h300, 4'd1, 4'd1, -1, 0, 0, nb, fa, la);
        check("postrst_first", fa, 12'h300);
        check("postrst_beats", nb, 4);

        for (int k = 0; k < 25; k++) begin
            run_cmd(1'($urandom), 1'($urandom), 12'($urandom),
                    4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                    int'($urandom_range(0, 5)), int'($urandom_range(0, 4)), 1, nb, fa, la);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
